dbchecker_ctrl_arbiter: RTL and testbench
=========================================

// Module: dbchecker_ctrl_arbiter
// PURPOSE
//  Shares the DBChecker AXI-Lite control port (s_axil_ctrl) between two requesters:
//  requester 0 (host/firmware) and requester 1 (untrusted agent). Grants one transaction at a
//  time, round-robin. Requester 1 may only reach a configured address window; out-of-window
//  accesses are answered locally with SLVERR, never forwarded, and counted.
// PARAMETERS
//  ADDR_W    32            AXI-Lite address width, all three ports
//  DATA_W    32            AXI-Lite data width; strobe width is DATA_W/8
//  S1_BASE   32'h0000_0100 base of the requester-1 permitted window
//  S1_MASK   32'hFFFF_FF00 window match mask: hit = (addr & S1_MASK) == S1_BASE
//  CNT_W     16            width of the deny counter
// PORTS
//  clock                     in  1       single clock
//  reset                     in  1       asynchronous reset, active-low (asserted at 0)
//  sN_axil_aw{valid,addr,prot} in 1/ADDR_W/3  write address from requester N (N=0,1); awready out 1
//  sN_axil_w{valid,data,strb}  in 1/DATA_W/DATA_W/8  write data from requester N; wready out 1
//  sN_axil_b{valid,resp}       out 1/2   write response to requester N; bready in 1
//  sN_axil_ar{valid,addr,prot} in 1/ADDR_W/3  read address from requester N; arready out 1
//  sN_axil_r{valid,data,resp}  out 1/DATA_W/2  read data to requester N; rready in 1
//  m_axil_{aw,w,b,ar,r}_*    mirror of one sN set, opposite directions; drives DBChecker s_axil_ctrl
//  deny_pulse                out 1       one-cycle pulse when a requester-1 access is denied
//  deny_cnt                  out CNT_W   saturating count of denied requester-1 accesses
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, b/r resp and rdata 0, deny_cnt 0, deny_pulse 0,
//   state IDLE, round-robin pointer = requester 0.
//  Request: wr_req[N] = awvalid & wvalid; rd_req[N] = arvalid. req[N] = wr_req|rd_req.
//   Within one requester, write beats read.
//  IDLE: if any req, grant registered that cycle; pointer picks first requester at or after it;
//   next pointer = other requester. Next state from grant + type + window check:
//   WR_FWD, RD_FWD, DENY_WA or DENY_RA. Requester 0 is never checked.
//  WR_FWD: m_awvalid = s_awvalid[g] & ~aw_done; m_wvalid = s_wvalid[g] & ~w_done; payload and
//   readies pass combinationally; aw_done/w_done set on each handshake; both done -> WR_RESP.
//  WR_RESP: m_bready = s_bready[g], s_bvalid[g] = m_bvalid, bresp passes; on handshake -> IDLE.
//  RD_FWD: m_arvalid/arready pass for granted requester; handshake -> RD_RESP.
//  RD_RESP: r channel passes to granted requester; on handshake -> IDLE.
//  DENY_WA: s1 awready=wready=1 for exactly one cycle -> DENY_B (bvalid=1, bresp=2'b10 until bready).
//  DENY_RA: s1 arready=1 one cycle -> DENY_R (rvalid=1, rdata=0, rresp=2'b10 until rready).
//  deny_pulse asserted in DENY_WA/DENY_RA cycle; deny_cnt +1 there, holds at all-ones.
//  Non-granted requester sees all readies/valids 0; its requests wait (valid held per AXI).
//  Latency: grant 1 cycle after req seen in IDLE; forwarding adds no further cycles.
//  One transaction in flight total; return to IDLE costs 1 cycle before next grant.
//  Simultaneous req from both in IDLE: pointer decides; equal service under saturation.
//  Reset mid-transaction: async to IDLE immediately; in-flight downstream transfer abandoned,
//   DBChecker and requesters must share the same reset.
// STRUCTURE
//  dbchecker_pkg: AXI-Lite resp constants (OKAY=2'b00, SLVERR=2'b10), arbiter state enum.
//  Sub-module axil_rr_arb2: 2-way round-robin pick + pointer register; FSM/muxing in this module.
// TESTING
//  1 s0 write addr 0x10 data 0xDEADBEEF, slave bresp OKAY -> m_aw/m_w carry it, s0 bresp 2'b00.
//  2 s1 read 0x104 (in window), slave rdata 0x1234 -> s1 gets 0x1234 OKAY, deny_cnt stays 0.
//  3 s1 write 0x200 (out of window) -> no m_awvalid ever, s1 bresp 2'b10, deny_pulse 1 cycle, deny_cnt 1.
//  4 s0 and s1 both assert reads every cycle for 8 transactions -> grants alternate 0,1,0,1..., 4 each.
//  5 s0 awvalid 3 cycles before wvalid, slave awready late -> one forwarded write, no duplicate AW.
//  6 reset low while in RD_RESP -> all outputs 0 next edge, next grant starts from requester 0.

Source files
------------

// File: rtl/dbchecker_pkg.sv
// Shared definitions for the DBChecker control-port arbiter.
//   RESP_OKAY / RESP_SLVERR : AXI-Lite response codes
//   arb_state_t             : transaction FSM state encoding
package dbchecker_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_FWD,
    ST_WR_RESP,
    ST_RD_FWD,
    ST_RD_RESP,
    ST_DENY_WA,
    ST_DENY_B,
    ST_DENY_RA,
    ST_DENY_R
  } arb_state_t;

endpackage

// File: rtl/axil_rr_arb2.sv
// Two-way round-robin pick with pointer register.
//   clk, rst_n : clock, async active-low reset (pointer -> requester 0)
//   req        : request vector, bit N = requester N
//   take       : a grant is being taken this cycle (pointer advances if any req)
//   pick       : requester chosen: the first requesting one at or after the pointer
module axil_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       pick
);

  logic ptr;

  always_comb begin
    pick = req[ptr] ? ptr : ~ptr;
  end

  // After a grant the other requester gets priority, giving equal service under saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (take && (|req)) begin
      ptr <= ~pick;
    end
  end

endmodule

// File: rtl/dbchecker_ctrl_arbiter.sv
// Shares the DBChecker AXI-Lite control port between requester 0 (host) and
// requester 1 (untrusted). One transaction in flight; round-robin grant.
// Requester-1 accesses outside its window are answered locally with SLVERR.
//   clk, rst_n       : clock, async active-low reset
//   s0_axil_* / s1_* : AXI-Lite slave ports for requesters 0 and 1
//   m_axil_*         : AXI-Lite master port towards DBChecker s_axil_ctrl
//   deny_pulse       : one cycle high per denied requester-1 access
//   deny_cnt         : saturating count of denied requester-1 accesses
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | no transaction; pick a requester and classify its access
// ST_WR_FWD   | forwarding AW and W of granted requester until both done
// ST_WR_RESP  | forwarding B back to granted requester
// ST_RD_FWD   | forwarding AR of granted requester
// ST_RD_RESP  | forwarding R back to granted requester
// ST_DENY_WA  | accept denied s1 AW+W locally (one cycle)
// ST_DENY_B   | local SLVERR write response to s1
// ST_DENY_RA  | accept denied s1 AR locally (one cycle)
// ST_DENY_R   | local SLVERR read response (data 0) to s1
module dbchecker_ctrl_arbiter
  import dbchecker_pkg::*;
#(
  parameter int                 ADDR_W  = 32,
  parameter int                 DATA_W  = 32,
  parameter logic [ADDR_W-1:0]  S1_BASE = ADDR_W'(32'h0000_0100),
  parameter logic [ADDR_W-1:0]  S1_MASK = ADDR_W'(32'hFFFF_FF00),
  parameter int                 CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  // requester 0
  input  logic                s0_axil_awvalid,
  input  logic [ADDR_W-1:0]   s0_axil_awaddr,
  input  logic [2:0]          s0_axil_awprot,
  output logic                s0_axil_awready,
  input  logic                s0_axil_wvalid,
  input  logic [DATA_W-1:0]   s0_axil_wdata,
  input  logic [DATA_W/8-1:0] s0_axil_wstrb,
  output logic                s0_axil_wready,
  output logic                s0_axil_bvalid,
  output logic [1:0]          s0_axil_bresp,
  input  logic                s0_axil_bready,
  input  logic                s0_axil_arvalid,
  input  logic [ADDR_W-1:0]   s0_axil_araddr,
  input  logic [2:0]          s0_axil_arprot,
  output logic                s0_axil_arready,
  output logic                s0_axil_rvalid,
  output logic [DATA_W-1:0]   s0_axil_rdata,
  output logic [1:0]          s0_axil_rresp,
  input  logic                s0_axil_rready,
  // requester 1
  input  logic                s1_axil_awvalid,
  input  logic [ADDR_W-1:0]   s1_axil_awaddr,
  input  logic [2:0]          s1_axil_awprot,
  output logic                s1_axil_awready,
  input  logic                s1_axil_wvalid,
  input  logic [DATA_W-1:0]   s1_axil_wdata,
  input  logic [DATA_W/8-1:0] s1_axil_wstrb,
  output logic                s1_axil_wready,
  output logic                s1_axil_bvalid,
  output logic [1:0]          s1_axil_bresp,
  input  logic                s1_axil_bready,
  input  logic                s1_axil_arvalid,
  input  logic [ADDR_W-1:0]   s1_axil_araddr,
  input  logic [2:0]          s1_axil_arprot,
  output logic                s1_axil_arready,
  output logic                s1_axil_rvalid,
  output logic [DATA_W-1:0]   s1_axil_rdata,
  output logic [1:0]          s1_axil_rresp,
  input  logic                s1_axil_rready,
  // downstream master
  output logic                m_axil_awvalid,
  output logic [ADDR_W-1:0]   m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  input  logic                m_axil_awready,
  output logic                m_axil_wvalid,
  output logic [DATA_W-1:0]   m_axil_wdata,
  output logic [DATA_W/8-1:0] m_axil_wstrb,
  input  logic                m_axil_wready,
  input  logic                m_axil_bvalid,
  input  logic [1:0]          m_axil_bresp,
  output logic                m_axil_bready,
  output logic                m_axil_arvalid,
  output logic [ADDR_W-1:0]   m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  input  logic                m_axil_arready,
  input  logic                m_axil_rvalid,
  input  logic [DATA_W-1:0]   m_axil_rdata,
  input  logic [1:0]          m_axil_rresp,
  output logic                m_axil_rready,
  // deny reporting
  output logic                deny_pulse,
  output logic [CNT_W-1:0]    deny_cnt
);

  arb_state_t state;
  logic       grant;
  logic       aw_done;
  logic       w_done;
  logic       pick;

  logic [1:0] wr_req, rd_req, req;
  logic       s1_aw_hit, s1_ar_hit;
  logic       aw_hs, w_hs;

  // requester-indexed views of the slave ports
  logic [1:0]          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [ADDR_W-1:0]   s_awaddr [2];
  logic [ADDR_W-1:0]   s_araddr [2];
  logic [2:0]          s_awprot [2];
  logic [2:0]          s_arprot [2];
  logic [DATA_W-1:0]   s_wdata  [2];
  logic [DATA_W/8-1:0] s_wstrb  [2];

  logic [1:0]          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]          s_bresp  [2];
  logic [1:0]          s_rresp  [2];
  logic [DATA_W-1:0]   s_rdata  [2];

  assign s_awvalid   = {s1_axil_awvalid, s0_axil_awvalid};
  assign s_wvalid    = {s1_axil_wvalid,  s0_axil_wvalid};
  assign s_bready    = {s1_axil_bready,  s0_axil_bready};
  assign s_arvalid   = {s1_axil_arvalid, s0_axil_arvalid};
  assign s_rready    = {s1_axil_rready,  s0_axil_rready};
  assign s_awaddr[0] = s0_axil_awaddr;
  assign s_awaddr[1] = s1_axil_awaddr;
  assign s_araddr[0] = s0_axil_araddr;
  assign s_araddr[1] = s1_axil_araddr;
  assign s_awprot[0] = s0_axil_awprot;
  assign s_awprot[1] = s1_axil_awprot;
  assign s_arprot[0] = s0_axil_arprot;
  assign s_arprot[1] = s1_axil_arprot;
  assign s_wdata[0]  = s0_axil_wdata;
  assign s_wdata[1]  = s1_axil_wdata;
  assign s_wstrb[0]  = s0_axil_wstrb;
  assign s_wstrb[1]  = s1_axil_wstrb;

  assign s0_axil_awready = s_awready[0];
  assign s1_axil_awready = s_awready[1];
  assign s0_axil_wready  = s_wready[0];
  assign s1_axil_wready  = s_wready[1];
  assign s0_axil_bvalid  = s_bvalid[0];
  assign s1_axil_bvalid  = s_bvalid[1];
  assign s0_axil_bresp   = s_bresp[0];
  assign s1_axil_bresp   = s_bresp[1];
  assign s0_axil_arready = s_arready[0];
  assign s1_axil_arready = s_arready[1];
  assign s0_axil_rvalid  = s_rvalid[0];
  assign s1_axil_rvalid  = s_rvalid[1];
  assign s0_axil_rdata   = s_rdata[0];
  assign s1_axil_rdata   = s_rdata[1];
  assign s0_axil_rresp   = s_rresp[0];
  assign s1_axil_rresp   = s_rresp[1];

  // Write needs both AW and W present; a write beats a read from the same requester.
  assign wr_req = s_awvalid & s_wvalid;
  assign rd_req = s_arvalid;
  assign req    = wr_req | rd_req;

  assign s1_aw_hit = (s1_axil_awaddr & S1_MASK) == S1_BASE;
  assign s1_ar_hit = (s1_axil_araddr & S1_MASK) == S1_BASE;

  axil_rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .take  (state == ST_IDLE),
    .pick  (pick)
  );

  // Payload always follows the granted requester; only valids/readies are gated.
  assign m_axil_awaddr = s_awaddr[grant];
  assign m_axil_awprot = s_awprot[grant];
  assign m_axil_wdata  = s_wdata[grant];
  assign m_axil_wstrb  = s_wstrb[grant];
  assign m_axil_araddr = s_araddr[grant];
  assign m_axil_arprot = s_arprot[grant];

  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid  & m_axil_wready;

  always_comb begin
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    s_awready      = 2'b00;
    s_wready       = 2'b00;
    s_bvalid       = 2'b00;
    s_arready      = 2'b00;
    s_rvalid       = 2'b00;
    s_bresp[0]     = RESP_OKAY;
    s_bresp[1]     = RESP_OKAY;
    s_rresp[0]     = RESP_OKAY;
    s_rresp[1]     = RESP_OKAY;
    s_rdata[0]     = '0;
    s_rdata[1]     = '0;
    unique case (state)
      ST_WR_FWD: begin
        // done flags stop a second AW/W beat if the requester holds valid after its handshake
        m_axil_awvalid   = s_awvalid[grant] & ~aw_done;
        m_axil_wvalid    = s_wvalid[grant]  & ~w_done;
        s_awready[grant] = m_axil_awready & ~aw_done;
        s_wready[grant]  = m_axil_wready  & ~w_done;
      end
      ST_WR_RESP: begin
        m_axil_bready   = s_bready[grant];
        s_bvalid[grant] = m_axil_bvalid;
        s_bresp[grant]  = m_axil_bresp;
      end
      ST_RD_FWD: begin
        m_axil_arvalid   = s_arvalid[grant];
        s_arready[grant] = m_axil_arready;
      end
      ST_RD_RESP: begin
        m_axil_rready   = s_rready[grant];
        s_rvalid[grant] = m_axil_rvalid;
        s_rdata[grant]  = m_axil_rdata;
        s_rresp[grant]  = m_axil_rresp;
      end
      ST_DENY_WA: begin
        s_awready[1] = 1'b1;
        s_wready[1]  = 1'b1;
      end
      ST_DENY_B: begin
        s_bvalid[1] = 1'b1;
        s_bresp[1]  = RESP_SLVERR;
      end
      ST_DENY_RA: begin
        s_arready[1] = 1'b1;
      end
      ST_DENY_R: begin
        s_rvalid[1] = 1'b1;
        s_rresp[1]  = RESP_SLVERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      deny_pulse <= 1'b0;
      deny_cnt   <= '0;
    end else begin
      deny_pulse <= 1'b0;
      if ((state == ST_DENY_WA || state == ST_DENY_RA) && (deny_cnt != '1)) begin
        deny_cnt <= deny_cnt + CNT_W'(1);
      end
      unique case (state)
        ST_IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (|req) begin
            grant <= pick;
            if (wr_req[pick]) begin
              if (pick && !s1_aw_hit) begin
                state      <= ST_DENY_WA;
                deny_pulse <= 1'b1;
              end else begin
                state <= ST_WR_FWD;
              end
            end else begin
              if (pick && !s1_ar_hit) begin
                state      <= ST_DENY_RA;
                deny_pulse <= 1'b1;
              end else begin
                state <= ST_RD_FWD;
              end
            end
          end
        end
        ST_WR_FWD: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_WR_RESP;
        end
        ST_WR_RESP: if (m_axil_bvalid && s_bready[grant])   state <= ST_IDLE;
        ST_RD_FWD:  if (s_arvalid[grant] && m_axil_arready) state <= ST_RD_RESP;
        ST_RD_RESP: if (m_axil_rvalid && s_rready[grant])   state <= ST_IDLE;
        ST_DENY_WA: state <= ST_DENY_B;
        ST_DENY_B:  if (s_bready[1]) state <= ST_IDLE;
        ST_DENY_RA: state <= ST_DENY_R;
        ST_DENY_R:  if (s_rready[1]) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbchecker_ctrl_arbiter.sv
// Scoreboard bench for dbchecker_ctrl_arbiter: requester tasks push expected
// responses per requester; a monitor pops and compares on every B/R handshake.
// Inputs change on negedge; everything is sampled 1 time unit before posedge.
module tb_dbchecker_ctrl_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // requester-side stimulus
  logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [31:0] araddr [2];
  logic [3:0]  wstrb  [2];
  logic [2:0]  awprot [2];
  logic [2:0]  arprot [2];
  wire  [1:0]  awready, wready, bvalid, arready, rvalid;
  wire  [1:0]  bresp [2];
  wire  [1:0]  rresp [2];
  wire  [31:0] rdata [2];

  // downstream slave model
  wire         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  wire  [31:0] m_awaddr, m_wdata, m_araddr;
  wire  [2:0]  m_awprot, m_arprot;
  wire  [3:0]  m_wstrb;
  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  wire         deny_pulse;
  wire  [15:0] deny_cnt;

  dbchecker_ctrl_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axil_awvalid(awvalid[0]), .s0_axil_awaddr(awaddr[0]), .s0_axil_awprot(awprot[0]),
    .s0_axil_awready(awready[0]),
    .s0_axil_wvalid(wvalid[0]), .s0_axil_wdata(wdata[0]), .s0_axil_wstrb(wstrb[0]),
    .s0_axil_wready(wready[0]),
    .s0_axil_bvalid(bvalid[0]), .s0_axil_bresp(bresp[0]), .s0_axil_bready(bready[0]),
    .s0_axil_arvalid(arvalid[0]), .s0_axil_araddr(araddr[0]), .s0_axil_arprot(arprot[0]),
    .s0_axil_arready(arready[0]),
    .s0_axil_rvalid(rvalid[0]), .s0_axil_rdata(rdata[0]), .s0_axil_rresp(rresp[0]),
    .s0_axil_rready(rready[0]),
    .s1_axil_awvalid(awvalid[1]), .s1_axil_awaddr(awaddr[1]), .s1_axil_awprot(awprot[1]),
    .s1_axil_awready(awready[1]),
    .s1_axil_wvalid(wvalid[1]), .s1_axil_wdata(wdata[1]), .s1_axil_wstrb(wstrb[1]),
    .s1_axil_wready(wready[1]),
    .s1_axil_bvalid(bvalid[1]), .s1_axil_bresp(bresp[1]), .s1_axil_bready(bready[1]),
    .s1_axil_arvalid(arvalid[1]), .s1_axil_araddr(araddr[1]), .s1_axil_arprot(arprot[1]),
    .s1_axil_arready(arready[1]),
    .s1_axil_rvalid(rvalid[1]), .s1_axil_rdata(rdata[1]), .s1_axil_rresp(rresp[1]),
    .s1_axil_rready(rready[1]),
    .m_axil_awvalid(m_awvalid), .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot),
    .m_axil_awready(m_awready),
    .m_axil_wvalid(m_wvalid), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
    .m_axil_wready(m_wready),
    .m_axil_bvalid(m_bvalid), .m_axil_bresp(m_bresp), .m_axil_bready(m_bready),
    .m_axil_arvalid(m_arvalid), .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot),
    .m_axil_arready(m_arready),
    .m_axil_rvalid(m_rvalid), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rready(m_rready),
    .deny_pulse(deny_pulse), .deny_cnt(deny_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   order_q[$];
  int   deny_pulses = 0;

  // slave model state
  int          aw_delay = 0;
  int          aw_wait = 0;
  int          aw_hs_cnt = 0;
  int          ar_hs_cnt = 0;
  int          aw_vcyc = 0;
  bit          have_aw = 0, have_w = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [2:0]  cap_prot = '0;
  logic        n_awready = 0, n_bvalid = 0, n_rvalid = 0;
  logic [1:0]  n_bresp = 0;
  logic [31:0] n_rdata = 0;

  // Slave: awready after aw_delay+1 waiting cycles, wready/arready always high,
  // bresp SLVERR only for address 0x3C, rdata = araddr + 0x1130.
  initial begin
    forever begin
      @(negedge clk);
      m_awready = n_awready;
      m_wready  = 1'b1;
      m_bvalid  = n_bvalid;
      m_bresp   = n_bresp;
      m_arready = 1'b1;
      m_rvalid  = n_rvalid;
      m_rdata   = n_rdata;
      m_rresp   = 2'b00;
      #4;
      if (!rst_n) begin
        n_awready = 0; n_bvalid = 0; n_rvalid = 0; aw_wait = 0;
        have_aw = 0; have_w = 0;
      end else begin
        if (m_awvalid) aw_vcyc++;
        if (m_awvalid && m_awready) begin
          aw_hs_cnt++; cap_awaddr = m_awaddr; cap_prot = m_awprot; have_aw = 1;
          n_awready = 0; aw_wait = 0;
        end else if (m_awvalid) begin
          aw_wait++;
          n_awready = (aw_wait > aw_delay);
        end
        if (m_wvalid && m_wready) begin
          cap_wdata = m_wdata; cap_wstrb = m_wstrb; have_w = 1;
        end
        if (m_bvalid && m_bready) n_bvalid = 0;
        if (have_aw && have_w && !n_bvalid) begin
          n_bvalid = 1;
          n_bresp  = (cap_awaddr == 32'h3C) ? 2'b10 : 2'b00;
          have_aw = 0; have_w = 0;
        end
        if (m_rvalid && m_rready) n_rvalid = 0;
        if (m_arvalid && m_arready) begin
          ar_hs_cnt++; cap_prot = m_arprot;
          n_rvalid = 1;
          n_rdata  = m_araddr + 32'h1130;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (deny_pulse) deny_pulses++;
        for (int i = 0; i < 2; i++) begin
          if (arvalid[i] && arready[i]) order_q.push_back(i);
          if (bvalid[i] && bready[i]) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
              chk($sformatf("s%0d_unexpected_b", i), 1, 0);
            end else begin
              e = (i == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("s%0d_b_is_write", i), 1, {63'd0, e.is_wr});
              chk($sformatf("s%0d_bresp", i), bresp[i], e.resp);
            end
          end
          if (rvalid[i] && rready[i]) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
              chk($sformatf("s%0d_unexpected_r", i), 1, 0);
            end else begin
              e = (i == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("s%0d_r_is_read", i), 0, {63'd0, e.is_wr});
              chk($sformatf("s%0d_rresp", i), rresp[i], e.resp);
              chk($sformatf("s%0d_rdata", i), rdata[i], e.data);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input int id, input bit is_wr, input logic [1:0] r, input logic [31:0] d);
    exp_t e;
    e.is_wr = is_wr; e.resp = r; e.data = d;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic wr(input int id, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] er, input int w_delay);
    bit aw_d = 0, w_d = 0;
    push_exp(id, 1, er, 32'h0);
    awaddr[id] = a; wdata[id] = d; wstrb[id] = 4'hF;
    awvalid[id] = 1'b1;
    wvalid[id]  = (w_delay == 0);
    for (int c = 0; c < 200 && !(aw_d && w_d); c++) begin
      #4;
      if (awvalid[id] && awready[id]) aw_d = 1;
      if (wvalid[id] && wready[id]) w_d = 1;
      @(negedge clk);
      if (aw_d) awvalid[id] = 1'b0;
      if (w_d) wvalid[id] = 1'b0;
      else if (c + 1 >= w_delay) wvalid[id] = 1'b1;
    end
    awvalid[id] = 1'b0; wvalid[id] = 1'b0;
    chk($sformatf("s%0d_wr_handshakes_0x%0h", id, a), {62'd0, aw_d, w_d}, 64'd3);
  endtask

  task automatic rd(input int id, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit hs = 0;
    push_exp(id, 0, er, ed);
    araddr[id] = a;
    arvalid[id] = 1'b1;
    for (int c = 0; c < 200 && !hs; c++) begin
      #4;
      if (arready[id]) hs = 1;
      @(negedge clk);
    end
    arvalid[id] = 1'b0;
    chk($sformatf("s%0d_ar_handshake_0x%0h", id, a), {63'd0, hs}, 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_outstanding", q0.size() + q1.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_aw, base_ar, base_vc;
    bit got;
    awvalid = '0; wvalid = '0; arvalid = '0; bready = 2'b11; rready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; wdata[i] = '0; araddr[i] = '0; wstrb[i] = '0;
      awprot[i] = '0; arprot[i] = '0;
    end
    #2;
    chk("rst_awready", {62'd0, awready}, 0);
    chk("rst_bvalid_rvalid", {60'd0, bvalid, rvalid}, 0);
    chk("rst_m_valids", {59'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("rst_resp_data", {28'd0, bresp[0], bresp[1], rresp[0], rdata[1]}, 0);
    chk("rst_deny", {47'd0, deny_pulse, deny_cnt}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: s0 write forwarded, slave OKAY; then slave SLVERR passes through
    wr(0, 32'h10, 32'hDEAD_BEEF, 2'b00, 0);
    drain();
    chk("t1_m_awaddr", cap_awaddr, 32'h10);
    chk("t1_m_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("t1_m_wstrb", cap_wstrb, 4'hF);
    wr(0, 32'h3C, 32'h5555_0000, 2'b10, 0);
    drain();

    // 2: s1 read in window
    rd(1, 32'h104, 32'h1234, 2'b00);
    drain();
    chk("t2_deny_cnt", deny_cnt, 0);
    chk("t2_deny_pulses", deny_pulses, 0);

    // 3: s1 write out of window, then s1 read out of window
    base_vc = aw_vcyc; base_aw = aw_hs_cnt; base_ar = ar_hs_cnt;
    wr(1, 32'h200, 32'hABCD, 2'b10, 0);
    drain();
    chk("t3_no_m_awvalid", aw_vcyc - base_vc, 0);
    chk("t3_no_m_aw_hs", aw_hs_cnt - base_aw, 0);
    chk("t3_deny_pulses", deny_pulses, 1);
    chk("t3_deny_cnt", deny_cnt, 1);
    rd(1, 32'h300, 32'h0, 2'b10);
    drain();
    chk("t3_no_m_ar_hs", ar_hs_cnt - base_ar, 0);
    chk("t3_deny_pulses_rd", deny_pulses, 2);
    chk("t3_deny_cnt_rd", deny_cnt, 2);

    // 4: both requesters saturate with reads
    order_q.delete();
    fork
      for (int k = 0; k < 4; k++) rd(0, 32'h20 + 32'(4 * k), 32'h1150 + 32'(4 * k), 2'b00);
      for (int k = 0; k < 4; k++) rd(1, 32'h120 + 32'(4 * k), 32'h1250 + 32'(4 * k), 2'b00);
    join
    drain();
    chk("t4_grant_count", order_q.size(), 8);
    for (int k = 0; k < 8 && k < order_q.size(); k++) chk($sformatf("t4_grant_%0d", k), order_q[k], k % 2);

    // 5: wvalid 3 cycles after awvalid, slave awready late
    base_aw = aw_hs_cnt;
    aw_delay = 4;
    wr(0, 32'h80, 32'hCAFE_F00D, 2'b00, 3);
    drain();
    aw_delay = 0;
    chk("t5_single_aw", aw_hs_cnt - base_aw, 1);
    chk("t5_m_awaddr", cap_awaddr, 32'h80);
    chk("t5_m_wdata", cap_wdata, 32'hCAFE_F00D);

    // 6: reset while s0 read response is pending
    rready[0] = 1'b0;
    araddr[0] = 32'h40; arvalid[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      #4;
      if (arready[0]) got = 1;
      @(negedge clk);
    end
    arvalid[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      #4;
      if (rvalid[0]) got = 1;
      @(negedge clk);
    end
    chk("t6_in_rd_resp", {63'd0, got}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_valids", {58'd0, rvalid, bvalid, arready}, 0);
    chk("t6_rst_rdata", rdata[0], 0);
    chk("t6_rst_m_ready", {62'd0, m_rready, m_arvalid}, 0);
    chk("t6_rst_deny_cnt", deny_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    rready[0] = 1'b1;
    @(negedge clk);
    order_q.delete();
    fork
      rd(0, 32'h50, 32'h1180, 2'b00);
      rd(1, 32'h150, 32'h1280, 2'b00);
    join
    drain();
    chk("t6_grant_count", order_q.size(), 2);
    if (order_q.size() >= 2) begin
      chk("t6_first_grant", order_q[0], 0);
      chk("t6_second_grant", order_q[1], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
